// File: rtl/gmii_tx_pkg.sv
// gmii_tx_pkg: shared state encoding, framing constants and CRC-32 helpers
// for the GMII transmit framer and its bench.
package gmii_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } tx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT          = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE       = 32'hC704DD7B;

    // MSB-first register form: data bits enter LSB first, as on the wire.
    function automatic logic [31:0] crc32_next(
        input logic [7:0]  d,
        input logic [31:0] crc
    );
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return c;
    endfunction

    function automatic logic [31:0] crc32_fcs(input logic [31:0] crc);
        logic [31:0] f;
        for (int i = 0; i < 32; i++) begin
            f[i] = ~crc[31-i];
        end
        return f;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: byte-wide Ethernet CRC-32 accumulator with clear and enable.
// Clear has priority over enable; shared by the TX framer and RX checker.
module eth_crc32_d8
    import gmii_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC_INIT;
        end else if (i_clear) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= crc32_next(i_data, r_crc);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: GMII TX framer (preamble, SFD, payload, FCS, IFG, underrun).
// Define GMII_TX_PAD_EN to zero-pad short frames to MIN_FRAME_LEN before FCS.
module gmii_tx_framer
    import gmii_tx_pkg::*;
#(
    parameter int PREAMBLE_LEN  = 7,
    parameter int IFG_LEN       = 12,
    parameter int MIN_FRAME_LEN = 60,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       PHY_TXD,
    output logic             PHY_TXCTL_TXEN,
    output logic             PHY_TXER,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] underrun_count
);

    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    localparam int IW = $clog2(IFG_LEN + 1);

    tx_state_t        r_state;
    tx_state_t        w_state_n;
    logic [7:0]       r_txd;
    logic [7:0]       w_txd_n;
    logic             r_txen;
    logic             w_txen_n;
    logic             r_txer;
    logic             w_txer_n;
    logic [PW-1:0]    r_pcnt;
    logic [PW-1:0]    w_pcnt_n;
    logic [1:0]       r_fcnt;
    logic [1:0]       w_fcnt_n;
    logic [IW-1:0]    r_icnt;
    logic [IW-1:0]    w_icnt_n;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_under_cnt;
    logic             w_frame_inc;
    logic             w_under_inc;
    logic             w_crc_clr;
    logic             w_crc_en;
    logic [7:0]       w_crc_din;
    logic [31:0]      w_crc;
    logic [31:0]      w_fcs;

`ifdef GMII_TX_PAD_EN
    localparam logic [10:0] MIN_L = 11'(MIN_FRAME_LEN);
    logic [10:0] r_bcnt;
    logic [10:0] w_bcnt_n;
    logic [10:0] w_bcnt_inc;
    logic [10:0] w_data_cnt;

    assign w_bcnt_inc = (r_bcnt == 11'h7FF) ? r_bcnt : r_bcnt + 11'd1;
    assign w_data_cnt = (r_state == ST_SFD) ? 11'd1 : w_bcnt_inc;
`endif

    eth_crc32_d8 u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_crc_clr),
        .i_en    (w_crc_en),
        .i_data  (w_crc_din),
        .o_crc   (w_crc)
    );

    assign w_fcs = crc32_fcs(w_crc);

    always_comb begin
        w_state_n   = r_state;
        w_txd_n     = r_txd;
        w_txen_n    = r_txen;
        w_txer_n    = r_txer;
        w_pcnt_n    = r_pcnt;
        w_fcnt_n    = r_fcnt;
        w_icnt_n    = r_icnt;
        w_frame_inc = 1'b0;
        w_under_inc = 1'b0;
        w_crc_clr   = 1'b0;
        w_crc_en    = 1'b0;
        w_crc_din   = s_data;
`ifdef GMII_TX_PAD_EN
        w_bcnt_n    = r_bcnt;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (s_valid) begin
                    w_state_n = ST_PREAMBLE;
                    w_txd_n   = ETH_PREAMBLE_BYTE;
                    w_txen_n  = 1'b1;
                    w_txer_n  = 1'b0;
                    w_pcnt_n  = PW'(1);
                    w_crc_clr = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                if (r_pcnt == PW'(PREAMBLE_LEN)) begin
                    w_state_n = ST_SFD;
                    w_txd_n   = ETH_SFD_BYTE;
                end else begin
                    w_txd_n  = ETH_PREAMBLE_BYTE;
                    w_pcnt_n = r_pcnt + PW'(1);
                end
            end
            // A missing first byte just stretches SFD; a gap later is fatal.
            ST_SFD, ST_DATA: begin
                if (s_valid) begin
                    w_txd_n  = s_data;
                    w_crc_en = 1'b1;
`ifdef GMII_TX_PAD_EN
                    w_bcnt_n = w_data_cnt;
`endif
                    if (s_last) begin
                        w_fcnt_n  = 2'd0;
                        w_state_n = ST_FCS;
`ifdef GMII_TX_PAD_EN
                        if (w_data_cnt < MIN_L) begin
                            w_state_n = ST_PAD;
                        end
`endif
                    end else begin
                        w_state_n = ST_DATA;
                    end
                end else if (r_state == ST_DATA) begin
                    w_txd_n     = 8'h00;
                    w_txer_n    = 1'b1;
                    w_under_inc = 1'b1;
                    w_state_n   = ST_DRAIN;
                end
            end
`ifdef GMII_TX_PAD_EN
            ST_PAD: begin
                w_txd_n   = 8'h00;
                w_crc_en  = 1'b1;
                w_crc_din = 8'h00;
                w_bcnt_n  = w_bcnt_inc;
                if (w_bcnt_inc >= MIN_L) begin
                    w_fcnt_n  = 2'd0;
                    w_state_n = ST_FCS;
                end
            end
`endif
            ST_FCS: begin
                w_txd_n  = w_fcs[{r_fcnt, 3'b000} +: 8];
                w_fcnt_n = r_fcnt + 2'd1;
                if (r_fcnt == 2'd3) begin
                    w_frame_inc = 1'b1;
                    w_icnt_n    = '0;
                    w_state_n   = ST_IFG;
                end
            end
            ST_DRAIN: begin
                w_txd_n  = 8'h00;
                w_txen_n = 1'b0;
                w_txer_n = 1'b0;
                if (s_valid && s_last) begin
                    w_icnt_n  = '0;
                    w_state_n = ST_IFG;
                end
            end
            ST_IFG: begin
                w_txd_n  = 8'h00;
                w_txen_n = 1'b0;
                w_txer_n = 1'b0;
                w_icnt_n = r_icnt + IW'(1);
                if (r_icnt == IW'(IFG_LEN - 1)) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_txd_n   = 8'h00;
                w_txen_n  = 1'b0;
                w_txer_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_txd       <= 8'h00;
            r_txen      <= 1'b0;
            r_txer      <= 1'b0;
            r_pcnt      <= '0;
            r_fcnt      <= '0;
            r_icnt      <= '0;
            r_frame_cnt <= '0;
            r_under_cnt <= '0;
        end else begin
            r_state <= w_state_n;
            r_txd   <= w_txd_n;
            r_txen  <= w_txen_n;
            r_txer  <= w_txer_n;
            r_pcnt  <= w_pcnt_n;
            r_fcnt  <= w_fcnt_n;
            r_icnt  <= w_icnt_n;
            if (w_frame_inc) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            if (w_under_inc) begin
                r_under_cnt <= r_under_cnt + CNT_W'(1);
            end
        end
    end

`ifdef GMII_TX_PAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= '0;
        end else begin
            r_bcnt <= w_bcnt_n;
        end
    end
`endif

    assign s_ready        = (r_state == ST_SFD) || (r_state == ST_DATA)
                         || (r_state == ST_DRAIN);
    assign busy           = (r_state != ST_IDLE);
    assign PHY_TXD        = r_txd;
    assign PHY_TXCTL_TXEN = r_txen;
    assign PHY_TXER       = r_txer;
    assign frame_count    = r_frame_cnt;
    assign underrun_count = r_under_cnt;

endmodule
